// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding, PC geometry, CSR vector bits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_pkg;

  localparam int unsigned PC_W      = 64;
  localparam logic [63:0] INST_STEP = 64'd4;

  // Boot address used when the top-level parameter is left at its default
  localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

  // Bit index inside csr_vec_h flagging an instruction-address-misaligned fetch
  localparam int unsigned CSRV_H_IMISALIGN = 0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } if_state_e;

  // SRAM rows are 64 bits wide, so the read address is the PC aligned down to 8 bytes
  function automatic logic [63:0] sram_row_addr(input logic [63:0] pc_in);
    return {pc_in[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/if_npc_sel.sv
// Next-PC / next-state priority mux for the fetch stage: flush > branch > stall > sequential.
// Latency: purely combinational, results are registered by if_fetch.
// Backpressure: stall holds everything except flush; a branch seen while stalled is parked in redir_pc.
module if_npc_sel
  import if_pkg::*;
(
  input  if_state_e   state,
  input  logic [63:0] pc_r,
  input  logic        valid_r,
  input  logic [63:0] redir_pc_r,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic        stall_if,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output if_state_e   nxt_state,
  output logic [63:0] nxt_pc,
  output logic        nxt_valid,
  output logic [63:0] nxt_redir_pc
);

  // Priority selection of the next fetch state; defaults hold every register
  always_comb begin
    nxt_state    = state;
    nxt_pc       = pc_r;
    nxt_valid    = valid_r;
    nxt_redir_pc = redir_pc_r;
    if (flush) begin
      // Trap/xret target overrides stalls and drops any parked branch
      nxt_pc    = flush_pc;
      nxt_valid = 1'b1;
      nxt_state = ST_RUN;
    end else if (br_e && !stall_if) begin
      nxt_pc    = br_addr;
      nxt_valid = 1'b1;
      nxt_state = ST_RUN;
    end else if (br_e && stall_if) begin
      // Park the newest target; the PC currently shown is wrong-path from now on
      nxt_redir_pc = br_addr;
      nxt_state    = ST_HOLD;
    end else if (!stall_if) begin
      unique case (state)
        ST_BOOT: begin
          nxt_state = ST_RUN;
          nxt_valid = 1'b1;
        end
        ST_HOLD: begin
          nxt_pc    = redir_pc_r;
          nxt_state = ST_RUN;
        end
        ST_RUN: begin
          nxt_pc = pc_r + INST_STEP;
        end
        default: begin
          nxt_state = ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, SRAM read port and IF->ID hand-off. Optional IF_MISALIGN_CHK_EN.
// Latency: redirect target on pc one cycle after the edge it is sampled; SRAM data one cycle after address.
// Backpressure: stall[0] freezes the PC; branches during stall are parked and replayed on release.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [63:0] flush_pc,
  input  logic [5:0]  stall,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  output logic        pc_valid,
  output logic [63:0] pc,
  output logic [31:0] csr_vec_h,
  output logic        inst_sram_en,
  output logic [63:0] inst_sram_addr
);

  if_state_e   state;
  logic [63:0] pc_r;
  logic        valid_r;
  logic [63:0] redir_pc_r;

  if_state_e   nxt_state;
  logic [63:0] nxt_pc;
  logic        nxt_valid;
  logic [63:0] nxt_redir_pc;

  // Only the IF stall bit matters here; later-stage bits are ignored
  logic unused_stall;
  assign unused_stall = ^stall[5:1];

  if_npc_sel u_npc_sel (
    .state        (state),
    .pc_r         (pc_r),
    .valid_r      (valid_r),
    .redir_pc_r   (redir_pc_r),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall_if     (stall[0]),
    .br_e         (br_e),
    .br_addr      (br_addr),
    .nxt_state    (nxt_state),
    .nxt_pc       (nxt_pc),
    .nxt_valid    (nxt_valid),
    .nxt_redir_pc (nxt_redir_pc)
  );

  // Fetch registers: synchronous reset to boot, otherwise take the mux result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      valid_r    <= 1'b0;
      redir_pc_r <= '0;
      state      <= ST_BOOT;
    end else begin
      pc_r       <= nxt_pc;
      valid_r    <= nxt_valid;
      redir_pc_r <= nxt_redir_pc;
      state      <= nxt_state;
    end
  end

  assign pc             = pc_r;
  // A PC shown while a parked redirect is pending is wrong-path and never valid
  assign pc_valid       = valid_r && (state != ST_HOLD);
  assign inst_sram_addr = sram_row_addr(pc_r);

`ifdef IF_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = pc_valid && (pc_r[1:0] != 2'b00);

  // Flag the misaligned fetch to ID and suppress the SRAM read; pc_valid stays up to carry the trap
  always_comb begin
    csr_vec_h                   = '0;
    csr_vec_h[CSRV_H_IMISALIGN] = misalign;
    inst_sram_en                = pc_valid && !misalign;
  end
`else
  // No alignment checking: fetch whenever the PC is valid and never raise an exception
  always_comb begin
    csr_vec_h    = '0;
    inst_sram_en = pc_valid;
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized redirect/stall/flush/reset traffic.
// Latency: model advances on each rising edge, outputs compared on each falling edge.
// Backpressure: random stall[0] with branches parked during stalls.
module tb_if_fetch;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [63:0] flush_pc;
  logic [5:0]  stall;
  logic        br_e;
  logic [63:0] br_addr;
  logic        pc_valid;
  logic [63:0] pc;
  logic [31:0] csr_vec_h;
  logic        inst_sram_en;
  logic [63:0] inst_sram_addr;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  if_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .stall          (stall),
    .br_e           (br_e),
    .br_addr        (br_addr),
    .pc_valid       (pc_valid),
    .pc             (pc),
    .csr_vec_h      (csr_vec_h),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr)
  );

  // Behavioural model: the architectural fetch PC, whether it is real, and a parked target
  logic [63:0] m_pc;
  bit          m_valid;
  bit          m_booting;
  bit          m_parked;
  logic [63:0] m_target;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_valid = 0; m_booting = 1; m_parked = 0; m_target = 0;
    end else if (flush) begin
      m_pc = flush_pc; m_valid = 1; m_booting = 0; m_parked = 0;
    end else if (br_e) begin
      if (stall[0]) begin
        m_target = br_addr; m_parked = 1; m_booting = 0;
      end else begin
        m_pc = br_addr; m_valid = 1; m_booting = 0; m_parked = 0;
      end
    end else if (!stall[0]) begin
      if (m_booting) begin
        m_booting = 0; m_valid = 1;
      end else if (m_parked) begin
        m_pc = m_target; m_parked = 0;
      end else begin
        m_pc = m_pc + 64'd4;
      end
    end
  end

  function automatic bit exp_valid();
    return m_valid && !m_parked;
  endfunction

  function automatic bit exp_misalign();
`ifdef IF_MISALIGN_CHK_EN
    return exp_valid() && (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_pc", pc, m_pc);
      check("m_pc_valid", {63'd0, pc_valid}, {63'd0, exp_valid()});
      check("m_sram_addr", inst_sram_addr, m_pc & ~64'h7);
      check("m_sram_en", {63'd0, inst_sram_en}, {63'd0, exp_valid() && !exp_misalign()});
      check("m_csr_vec_h", {32'd0, csr_vec_h}, {63'd0, exp_misalign()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; flush = 0; flush_pc = 0; stall = 0; br_e = 0; br_addr = 0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_pc", pc, RST_PC);
    check("rst_valid", {63'd0, pc_valid}, 64'd0);
    check("rst_csr", {32'd0, csr_vec_h}, 64'd0);
    check("rst_en", {63'd0, inst_sram_en}, 64'd0);
    check("rst_addr", inst_sram_addr, RST_PC & ~64'h7);

    // Boot sequence
    rst_n = 1;
    check("c0_valid", {63'd0, pc_valid}, 64'd0);
    check("c0_pc", pc, 64'h8000_0000);
    tick();
    check("c1_valid", {63'd0, pc_valid}, 64'd1);
    check("c1_pc", pc, 64'h8000_0000);
    check("c1_addr", inst_sram_addr, 64'h8000_0000);
    tick();
    check("c2_pc", pc, 64'h8000_0004);
    check("c2_addr", inst_sram_addr, 64'h8000_0000);
    tick();
    check("c3_pc", pc, 64'h8000_0008);
    tick(); tick();
    check("run_pc10", pc, 64'h8000_0010);

    // Unstalled branch
    br_e = 1; br_addr = 64'h8000_0100;
    tick();
    br_e = 0;
    check("br_pc", pc, 64'h8000_0100);
    tick();
    check("br_seq", pc, 64'h8000_0104);

    // Branches while stalled, newest wins
    stall = 6'b000001; br_e = 1; br_addr = 64'h8000_0200;
    tick();
    check("hold1_valid", {63'd0, pc_valid}, 64'd0);
    check("hold1_pc", pc, 64'h8000_0104);
    br_addr = 64'h8000_0300;
    tick();
    br_e = 0;
    check("hold2_valid", {63'd0, pc_valid}, 64'd0);
    check("hold2_pc", pc, 64'h8000_0104);
    tick();
    check("hold3_pc", pc, 64'h8000_0104);
    stall = 0;
    tick();
    check("hold_rel_pc", pc, 64'h8000_0300);
    check("hold_rel_valid", {63'd0, pc_valid}, 64'd1);

    // Flush beats simultaneous branch and stall
    flush = 1; flush_pc = 64'h8000_1000; br_e = 1; br_addr = 64'h8000_0200; stall = 6'b000001;
    tick();
    flush = 0; br_e = 0; stall = 0;
    check("flush_pc", pc, 64'h8000_1000);
    check("flush_valid", {63'd0, pc_valid}, 64'd1);
    tick();
    check("flush_seq", pc, 64'h8000_1004);

    // PC wrap
    br_e = 1; br_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_e = 0;
    check("wrap_pre", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_zero", pc, 64'h0);

    // Misaligned target
    br_e = 1; br_addr = 64'h8000_0002;
    tick();
    br_e = 0;
    check("mis_valid", {63'd0, pc_valid}, 64'd1);
`ifdef IF_MISALIGN_CHK_EN
    check("mis_csr", {32'd0, csr_vec_h}, 64'd1);
    check("mis_en", {63'd0, inst_sram_en}, 64'd0);
`else
    check("mis_csr", {32'd0, csr_vec_h}, 64'd0);
    check("mis_en", {63'd0, inst_sram_en}, 64'd1);
`endif
    tick();
    check("mis_seq", pc, 64'h8000_0006);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      rst_n    = ($urandom_range(99) >= 2);
      flush    = ($urandom_range(99) < 5);
      flush_pc = {$urandom, $urandom};
      if ($urandom_range(3) != 0) flush_pc[1:0] = 2'b00;
      stall    = 6'($urandom);
      stall[0] = ($urandom_range(99) < 35);
      br_e     = ($urandom_range(99) < 15);
      br_addr  = {$urandom, $urandom};
      if ($urandom_range(3) != 0) br_addr[1:0] = 2'b00;
      tick();
    end
    rst_n = 1; flush = 0; br_e = 0; stall = 0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that generates the program counter, drives the 64-bit instruction SRAM read port, and hands `pc`, `pc_valid` and `csr_vec_h` to the decode stage. It is the producing end of the IF→ID interface. The SRAM returns data one cycle after the address is presented. ID selects the 32-bit half by `pc[2]`. The block owns reset boot, sequential fetch, branch redirect (including redirects that arrive while IF is stalled) and flush/trap redirect.

## Interface
- `RESET_PC`, default 64'h0000_0000_8000_0000: first fetched address after reset.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  trap/xret redirect, highest priority after reset.
- `flush_pc`  in  64  target when `flush`=1.
- `stall`  in  6  pipeline stall vector; only `stall[0]` (IF stall) is used.
- `br_e`  in  1  branch/jump taken, resolved in EX.
- `br_addr`  in  64  branch target.
- `pc_valid`  out  1  `pc` holds a real instruction.
- `pc`  out  64  current fetch PC to ID.
- `csr_vec_h`  out  32  fetch-side exception vector, upper half of the ID CSR vector.
- `inst_sram_en`  out  1  SRAM read enable.
- `inst_sram_addr`  out  64  `{pc[63:3],3'b000}`.

## Operation
- States: BOOT, RUN, HOLD.
- Registers: `pc_r`, `valid_r`, `redir_pc_r`, state.
- Edge priority, first match wins:
  - `!rst_n`: `pc_r`=RESET_PC, `valid_r`=0, `redir_pc_r`=0, state=BOOT.
  - `flush`: `pc_r`=`flush_pc`, `valid_r`=1, state=RUN. Any pending redirect is dropped. Applies even when `stall[0]`=1.
  - `br_e & !stall[0]`: `pc_r`=`br_addr`, `valid_r`=1, state=RUN.
  - `br_e & stall[0]`: `redir_pc_r`=`br_addr`, state=HOLD, `pc_r` held. A newer `br_e` in HOLD overwrites `redir_pc_r`.
  - `stall[0]`: all registers held.
  - BOOT, not stalled: state=RUN, `valid_r`=1, `pc_r` unchanged (RESET_PC).
  - HOLD, not stalled: `pc_r`=`redir_pc_r`, state=RUN.
  - RUN, not stalled: `pc_r`=`pc_r`+4, modulo 2^64; wraps to 0.
- Outputs:
  - `pc`=`pc_r`.
  - `pc_valid`=`valid_r & (state!=HOLD)`. Wrong-path PCs in HOLD are never valid.
  - `inst_sram_en`=`pc_valid`, gated further by the misalign check when that feature is enabled.
- The instruction after a taken branch is still presented for one cycle. ID discards it, so IF does not suppress it.

## Timing
- Reset values: `pc`=RESET_PC, `pc_valid`=0, `csr_vec_h`=0, `inst_sram_en`=0, `inst_sram_addr`=RESET_PC & ~7.
- First valid fetch: the cycle after `rst_n` rises, given `stall[0]`=0.
- Address-to-data latency is 1 cycle. `pc` changes only at edges, so ID latches `pc` at edge N and consumes `inst_sram_rdata` during cycle N+1.
- Redirect latency: a target on `br_addr` or `flush_pc` at edge N appears on `pc` in cycle N+1. A HOLD redirect appears one cycle after the first unstalled edge.
- `flush` and `br_e` asserted in the same cycle: the flush target wins.
- Reset asserted mid-HOLD: the pending redirect is lost and the block returns to BOOT.

## Configuration
- `IF_MISALIGN_CHK_EN` defined:
  - When `pc_valid` and `pc[1:0]`!=0, `csr_vec_h[0]`=1 (instruction-address-misaligned).
  - In that case `inst_sram_en`=0 and `pc_valid` stays 1, so the exception propagates.
  - The PC keeps incrementing until the flush arrives.
- Undefined: `csr_vec_h` is constant 0 and no alignment gating is applied.

## Structure
- Shared package `if_pkg`:
  - state enum (BOOT/RUN/HOLD)
  - default RESET_PC
  - `CSRV_H_IMISALIGN` = 0 (bit index)
  - PC width 64 and instruction step 4
- One natural sub-module: `if_npc_sel`, a combinational next-PC/next-state priority mux. The top level holds the registers and output logic.

## Test plan
- Reset released, `stall`=0:
  - cycle 0: `pc_valid`=0, `pc`=0x8000_0000
  - cycle 1: `pc_valid`=1, `pc`=0x8000_0000
  - cycles 2 and 3: `pc`=0x8000_0004, then 0x8000_0008
  - `inst_sram_addr` shows 0x8000_0000 in cycles 1 and 2.
- In RUN at pc 0x8000_0010, `br_e`=1 and `br_addr`=0x8000_0100 for one cycle -> next cycle `pc`=0x8000_0100, then 0x8000_0104.
- `stall[0]`=1 for 3 cycles, with `br_e`=1 to 0x8000_0200 in the first stalled cycle and `br_e`=1 to 0x8000_0300 in the second:
  - during the stall: `pc_valid`=0 and `pc` held
  - after release: `pc`=0x8000_0300, `pc_valid`=1
- `flush`=1 with `flush_pc`=0x8000_1000, `br_e`=1 to 0x8000_0200 in the same cycle, and `stall[0]`=1 -> next cycle `pc`=0x8000_1000, state RUN, no later jump to 0x8000_0200.
- `pc_r`=64'hFFFF_FFFF_FFFF_FFFC, unstalled -> `pc`=0.
- `IF_MISALIGN_CHK_EN` defined, `br_addr`=0x8000_0002 -> `csr_vec_h`=0x1, `inst_sram_en`=0, `pc_valid`=1. With the macro undefined: `csr_vec_h`=0 and `inst_sram_en`=1.
